// File: rtl/data_mem_responder.sv
// Serialized byte/half/word data memory responder: IDLE -> ACCESS -> RESP per request.
// Optional MISALIGN_TRAP_EN turns misaligned half/word accesses into errors instead of aligning them down.
module data_mem_responder #(
  parameter int DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] mem_write,
  input  logic [1:0]  size,
  input  logic        unsigned_ld,
  output logic [31:0] mem_read,
  output logic        ready,
  output logic        err
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [1:0]      lane_q, lane_d;
  logic [1:0]      size_q, size_d;
  logic            uns_q, uns_d;
  logic            store_q, store_d;
  logic            perr_q, perr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [3:0]      be_q, be_d;
  logic [31:0]     mem_read_q, mem_read_d;
  logic            ready_q, ready_d;
  logic            err_q, err_d;

  logic [31:0]     mem_array [DEPTH];
  logic [31:0]     rd_word_q;

  logic [AW-1:0]   req_idx;
  logic [1:0]      req_lane;
  logic [3:0]      req_be;
  logic [31:0]     req_wdata;
  logic            req_err;
  logic            req_misalign;
  logic [31:0]     load_lane;
  logic [31:0]     load_ext;

  assign req_idx = addr[AW+1:2];

`ifdef MISALIGN_TRAP_EN
  assign req_misalign = ((size == 2'b01) && addr[0]) ||
                        ((size == 2'b10) && (addr[1:0] != 2'b00));
`else
  assign req_misalign = 1'b0;
`endif

  assign req_err = (rd_en && wr_en) || (size == 2'b11) ||
                   (addr[31:AW+2] != '0) || req_misalign;

  // Lane and byte enables use the aligned-down address; with trapping on, misaligned cases are errored anyway.
  always_comb begin
    req_lane  = 2'b00;
    req_be    = 4'b0000;
    req_wdata = mem_write;
    unique case (size)
      2'b00: begin
        req_lane  = addr[1:0];
        req_be    = 4'b0001 << addr[1:0];
        req_wdata = {4{mem_write[7:0]}};
      end
      2'b01: begin
        req_lane  = {addr[1], 1'b0};
        req_be    = addr[1] ? 4'b1100 : 4'b0011;
        req_wdata = {2{mem_write[15:0]}};
      end
      2'b10: begin
        req_be    = 4'b1111;
      end
      default: begin
        req_be    = 4'b0000;
      end
    endcase
  end

  always_comb begin
    load_lane = rd_word_q >> {lane_q, 3'b000};
    unique case (size_q)
      2'b00:   load_ext = uns_q ? {24'd0, load_lane[7:0]}
                                : {{24{load_lane[7]}}, load_lane[7:0]};
      2'b01:   load_ext = uns_q ? {16'd0, load_lane[15:0]}
                                : {{16{load_lane[15]}}, load_lane[15:0]};
      default: load_ext = rd_word_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    lane_d     = lane_q;
    size_d     = size_q;
    uns_d      = uns_q;
    store_d    = store_q;
    perr_d     = perr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    mem_read_d = mem_read_q;
    ready_d    = ready_q;
    err_d      = err_q;
    unique case (state_q)
      IDLE: begin
        if (rd_en || wr_en) begin
          state_d = ACCESS;
          idx_d   = req_idx;
          lane_d  = req_lane;
          size_d  = size;
          uns_d   = unsigned_ld;
          store_d = wr_en;
          perr_d  = req_err;
          wdata_d = req_wdata;
          be_d    = req_be;
        end
      end
      ACCESS: begin
        state_d    = RESP;
        ready_d    = 1'b1;
        err_d      = perr_q;
        mem_read_d = (perr_q || store_q) ? 32'd0 : load_ext;
      end
      RESP: begin
        state_d = IDLE;
        ready_d = 1'b0;
        err_d   = 1'b0;
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b0;
        err_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      lane_q     <= 2'b00;
      size_q     <= 2'b00;
      uns_q      <= 1'b0;
      store_q    <= 1'b0;
      perr_q     <= 1'b0;
      wdata_q    <= 32'd0;
      be_q       <= 4'b0000;
      mem_read_q <= 32'd0;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      lane_q     <= lane_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
      store_q    <= store_d;
      perr_q     <= perr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      mem_read_q <= mem_read_d;
      ready_q    <= ready_d;
      err_q      <= err_d;
    end
  end

  // Array is never reset; an async reset during ACCESS drops state to IDLE so the commit below never fires.
  always_ff @(posedge clk) begin
    rd_word_q <= mem_array[idx_d];
    if ((state_q == ACCESS) && store_q && !perr_q) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) mem_array[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  assign mem_read = mem_read_q;
  assign ready    = ready_q;
  assign err      = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized bench for data_mem_responder against a byte-addressed reference memory.
// Expected misalignment behaviour follows MISALIGN_TRAP_EN, same as the design.
module tb_data_mem_responder;
  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] mem_write;
  logic [1:0]  size;
  logic        unsigned_ld;
  logic [31:0] mem_read;
  logic        ready;
  logic        err;

  data_mem_responder #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .addr(addr), .rd_en(rd_en), .wr_en(wr_en),
    .mem_write(mem_write), .size(size), .unsigned_ld(unsigned_ld),
    .mem_read(mem_read), .ready(ready), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic        err;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  mbytes [DEPTH*4];
  logic [31:0] exp_last;
  int          cyc = 0;
  int          test_cnt = 0;
  int          fail_cnt = 0;
  logic        checking = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    test_cnt++;
    if (act !== expv) begin
      fail_cnt++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Reference: plain byte memory, little-endian, with size/range/misalignment rules applied directly.
  function automatic void model(input logic r, input logic w, input logic [31:0] a,
                                input logic [31:0] d, input logic [1:0] sz, input logic u,
                                output logic e, output logic [31:0] v);
    int nb;
    int ea;
    e  = (r && w) || (sz == 2'b11) || (a >= 32'(DEPTH*4));
    nb = 1 << sz;
    v  = 32'd0;
`ifdef MISALIGN_TRAP_EN
    if (!e && ((a % nb) != 0)) e = 1'b1;
`endif
    if (e) return;
    ea = int'(a) - int'(a % nb);
    if (w) for (int i = 0; i < nb; i++) mbytes[ea+i] = d[8*i +: 8];
    if (r) begin
      for (int i = 0; i < nb; i++) v[8*i +: 8] = mbytes[ea+i];
      if (!u && nb < 4 && v[8*nb-1])
        for (int i = nb; i < 4; i++) v[8*i +: 8] = 8'hFF;
    end
  endfunction

  // Every cycle: ready must appear exactly when the model says, err/mem_read checked against it.
  always @(negedge clk) begin
    if (checking && !rst) begin
      logic exp_rdy;
      exp_rdy = (exp_q.size() > 0) && (exp_q[0].due == cyc);
      chk("ready", {31'd0, ready}, {31'd0, exp_rdy});
      if (exp_rdy) begin
        chk("err", {31'd0, err}, {31'd0, exp_q[0].err});
        chk("mem_read", mem_read, exp_q[0].data);
        exp_last = exp_q[0].data;
        void'(exp_q.pop_front());
      end else begin
        chk("err_idle", {31'd0, err}, 32'd0);
        chk("mem_read_hold", mem_read, exp_last);
        if ((exp_q.size() > 0) && (exp_q[0].due < cyc)) void'(exp_q.pop_front());
      end
    end
  end

  task automatic req(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [1:0] sz, input logic u,
                     output logic [31:0] got, output logic gerr);
    exp_t e;
    int   n;
    @(negedge clk);
    model(r, w, a, d, sz, u, e.err, e.data);
    e.due = cyc + 2;
    exp_q.push_back(e);
    rd_en = r; wr_en = w; addr = a; mem_write = d; size = sz; unsigned_ld = u;
    got = 32'd0; gerr = 1'b0; n = 0;
    forever begin
      @(negedge clk);
      if (ready) begin
        got = mem_read; gerr = err;
        break;
      end
      n++;
      if (n > 8) begin
        test_cnt++; fail_cnt++;
        $display("FAIL ready_timeout: got no ready expected ready within 8 cycles (addr %h)", a);
        break;
      end
    end
    rd_en = 1'b0; wr_en = 1'b0;
    $display("[TB] txn rd=%0d wr=%0d addr=%h size=%0d uns=%0d wdata=%h -> rdata=%h err=%0d",
             r, w, a, sz, u, d, got, gerr);
  endtask

  logic [31:0] g;
  logic        ge;

  initial begin
    rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; addr = '0; mem_write = '0;
    size = 2'b00; unsigned_ld = 1'b0; exp_last = 32'd0;
    repeat (3) @(negedge clk);
    chk("reset_ready", {31'd0, ready}, 32'd0);
    chk("reset_err", {31'd0, err}, 32'd0);
    chk("reset_mem_read", mem_read, 32'd0);
    rst = 1'b0;
    checking = 1'b1;

    for (int i = 0; i < DEPTH; i++) req(1'b0, 1'b1, 32'(i*4), $urandom, 2'b10, 1'b0, g, ge);

    req(0, 1, 32'h10, 32'hDEADBEEF, 2'b10, 0, g, ge);
    chk("sw_err", {31'd0, ge}, 32'd0);
    chk("sw_data_zero", g, 32'd0);
    req(1, 0, 32'h10, 32'h0, 2'b10, 0, g, ge);
    chk("lw_10", g, 32'hDEADBEEF);
    chk("lw_10_err", {31'd0, ge}, 32'd0);

    req(0, 1, 32'h20, 32'h11223344, 2'b10, 0, g, ge);
    req(0, 1, 32'h22, 32'h000000AA, 2'b00, 0, g, ge);
    req(1, 0, 32'h20, 32'h0, 2'b10, 0, g, ge);
    chk("lw_20_lanes", g, 32'h11AA3344);
    req(1, 0, 32'h22, 32'h0, 2'b00, 0, g, ge);
    chk("lb_22", g, 32'hFFFFFFAA);
    req(1, 0, 32'h22, 32'h0, 2'b00, 1, g, ge);
    chk("lbu_22", g, 32'h000000AA);

    req(0, 1, 32'h30, 32'h00008001, 2'b01, 0, g, ge);
    req(1, 0, 32'h30, 32'h0, 2'b01, 0, g, ge);
    chk("lh_30", g, 32'hFFFF8001);
    req(1, 0, 32'h30, 32'h0, 2'b01, 1, g, ge);
    chk("lhu_30", g, 32'h00008001);

    req(1, 1, 32'h0, 32'h0, 2'b10, 0, g, ge);
    chk("both_en_err", {31'd0, ge}, 32'd1);
    req(0, 1, 32'h0, 32'hCAFEF00D, 2'b10, 0, g, ge);
    req(0, 1, 32'h400, 32'h12345678, 2'b10, 0, g, ge);
    chk("range_err", {31'd0, ge}, 32'd1);
    req(1, 0, 32'h0, 32'h0, 2'b10, 0, g, ge);
    chk("range_no_write", g, 32'hCAFEF00D);
    req(1, 0, 32'h10, 32'h0, 2'b11, 0, g, ge);
    chk("size11_err", {31'd0, ge}, 32'd1);
    chk("size11_data", g, 32'd0);

    req(1, 0, 32'h13, 32'h0, 2'b10, 0, g, ge);
`ifdef MISALIGN_TRAP_EN
    chk("misalign_err", {31'd0, ge}, 32'd1);
    chk("misalign_data", g, 32'd0);
`else
    chk("misalign_err", {31'd0, ge}, 32'd0);
    chk("misalign_data", g, 32'hDEADBEEF);
`endif

    // Store discarded by a reset pulse landing in ACCESS; the model is deliberately not updated.
    req(0, 1, 32'h40, 32'hA5A5A5A5, 2'b10, 0, g, ge);
    @(negedge clk);
    rd_en = 1'b0; wr_en = 1'b1; addr = 32'h40; mem_write = 32'h12345678; size = 2'b10;
    @(negedge clk);
    #1 rst = 1'b1; wr_en = 1'b0; exp_last = 32'd0;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    $display("[TB] txn rd=0 wr=1 addr=00000040 size=2 reset during ACCESS, no ready expected");
    req(1, 0, 32'h40, 32'h0, 2'b10, 0, g, ge);
    chk("reset_discard_store", g, 32'hA5A5A5A5);

    for (int i = 0; i < 400; i++) begin
      logic        r, w, u;
      logic [1:0]  sz;
      logic [31:0] a;
      r  = 1'($urandom_range(0, 1));
      w  = ~r;
      if ($urandom_range(0, 19) == 0) begin r = 1'b1; w = 1'b1; end
      sz = 2'($urandom_range(0, 2));
      if ($urandom_range(0, 19) == 0) sz = 2'b11;
      a  = 32'($urandom_range(0, DEPTH*4-1));
      if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
      if ($urandom_range(0, 19) == 0) a = a | (32'h400 << $urandom_range(0, 21));
      u  = 1'($urandom_range(0, 1));
      req(r, w, a, $urandom, sz, u, g, ge);
    end

    repeat (3) @(negedge clk);
    checking = 1'b0;
    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule
